// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory request/response and decode handshake bundle for fetch_unit
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                   o_mem_req_valid;
  logic [ADDR_WIDTH-1:0]  o_mem_req_addr;
  logic                   i_mem_req_ready;
  logic                   i_mem_rsp_valid;
  logic [INSTR_WIDTH-1:0] i_mem_rsp_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [INSTR_WIDTH-1:0] o_instruction;
  logic [ADDR_WIDTH-1:0]  o_pc;
  logic [ADDR_WIDTH-1:0]  o_pc_plus4;

  modport master (
    output o_mem_req_valid, o_mem_req_addr,
    input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
    output o_valid, o_instruction, o_pc, o_pc_plus4,
    input  i_ready
  );

  modport slave (
    input  o_mem_req_valid, o_mem_req_addr,
    output i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
    input  o_valid, o_instruction, o_pc, o_pc_plus4,
    output i_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-flow fetch stage with in-order fetch queue and redirect squashing
// Optional FETCH_ALIGN_CHECK_EN adds a sticky o_misaligned flag that blocks fetch after an unaligned redirect.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    FQ_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_pc_src,
  input  logic [ADDR_WIDTH-1:0] i_pc_target,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                  o_misaligned,
`endif
  fetch_unit_if.master          bus
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam logic [CW+1:0]       DEPTH_U = (CW + 2)'(FQ_DEPTH);
  localparam logic [CW-1:0]       DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]          out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [INSTR_WIDTH-1:0] fq_instr_q [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0]  fq_pc_q    [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0]  fq_pc4_q   [FQ_DEPTH];

  logic [CW+1:0] used;
  logic          credit_ok, req_block, req_valid, req_fire;
  logic          rsp_live, rsp_drop, push, head_valid, pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (i_pc_src) mis_d = |i_pc_target[1:0];
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) mis_q <= 1'b0;
    else         mis_q <= mis_d;
  end

  assign req_block    = mis_q;
  assign o_misaligned = mis_q;
`else
  assign req_block = 1'b0;
`endif

  // Every slot already claimed (in flight, being squashed, or queued) costs one credit.
  assign used      = {2'b00, out_q} + {2'b00, drop_q} + {2'b00, cnt_q};
  assign credit_ok = used < DEPTH_U;
  assign req_valid = i_arst & credit_ok & ~i_pc_src & ~req_block;
  assign req_fire  = req_valid & bus.i_mem_req_ready;

  assign rsp_drop   = bus.i_mem_rsp_valid & (drop_q != '0);
  assign rsp_live   = bus.i_mem_rsp_valid & (drop_q == '0);
  assign push       = rsp_live & ~i_pc_src;
  assign head_valid = (cnt_q != '0) & ~i_pc_src & ~req_block;
  assign pop        = head_valid & bus.i_ready;

  assign bus.o_mem_req_valid = req_valid;
  assign bus.o_mem_req_addr  = pc_q;
  assign bus.o_valid         = head_valid;
  assign bus.o_instruction   = fq_instr_q[rd_ptr_q];
  assign bus.o_pc            = fq_pc_q[rd_ptr_q];
  assign bus.o_pc_plus4      = fq_pc4_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_pc_src) begin
      // All still-live requests become squashed; a response this cycle retires one of them.
      pc_d     = i_pc_target;
      rsp_pc_d = i_pc_target;
      drop_d   = drop_q + out_q - CW'(bus.i_mem_rsp_valid);
      out_d    = '0;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (req_fire) pc_d = pc_q + PC_STEP;
      if (push) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      out_d  = out_q + CW'(req_fire) - CW'(rsp_live);
      drop_d = drop_q - CW'(rsp_drop);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_instr_q[i] <= '0;
        fq_pc_q[i]    <= '0;
        fq_pc4_q[i]   <= '0;
      end
    end else if (push) begin
      fq_instr_q[wr_ptr_q] <= bus.i_mem_rsp_data;
      fq_pc_q[wr_ptr_q]    <= rsp_pc_q;
      fq_pc4_q[wr_ptr_q]   <= rsp_pc_q + PC_STEP;
    end
  end

  overflow_chk: assert property (@(posedge i_clk) disable iff (!i_arst)
    push |-> (cnt_q < DEPTH_C));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit with an in-order variable-latency memory model
module tb_fetch_unit;
  localparam int AW = 64;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RST_PC = 64'h0;

  typedef struct {
    int            due;
    logic [IW-1:0] data;
    int            epoch;
  } rsp_t;

  logic clk = 1'b0;
  logic arst;
  logic pc_src;
  logic [AW-1:0] pc_target;
`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
`endif

  fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FQ_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_clk       (clk),
    .i_arst      (arst),
    .i_pc_src    (pc_src),
    .i_pc_target (pc_target),
`ifdef FETCH_ALIGN_CHECK_EN
    .o_misaligned(misaligned),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  int cyc = 0, rel_cyc = 0, fires = 0;
  int p_rdy = 100, p_mrdy = 100, lat_min = 1, lat_max = 1;
  int epoch = 0, model_qcnt = 0, last_due = 0, cur_rsp_epoch = 0;
  bit model_mis = 0, want_first = 0, hold_pending = 0;
  logic [AW-1:0] hold_addr = '0, gen_pc = RST_PC, req_exp = RST_PC;
  rsp_t memq[$];
  logic [AW-1:0] exp_q[$];

  function automatic logic [IW-1:0] instr_at(input logic [AW-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic flush_model();
    memq.delete();
    exp_q.delete();
    gen_pc       = RST_PC;
    req_exp      = RST_PC;
    model_qcnt   = 0;
    model_mis    = 0;
    hold_pending = 0;
    last_due     = 0;
    epoch++;
  endtask

  task automatic step(input bit redir = 0, input logic [AW-1:0] tgt = '0);
    @(negedge clk);
    cyc++;
    if (!arst) rel_cyc = cyc;
    arst                = 1'b1;
    bus.i_ready         = ($urandom_range(99) < p_rdy);
    bus.i_mem_req_ready = ($urandom_range(99) < p_mrdy);
    pc_src              = redir;
    pc_target           = redir ? tgt : {$urandom, $urandom};
    if (redir) begin
      exp_q.delete();
      gen_pc = tgt;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc += 64'd4;
    end
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      bus.i_mem_rsp_valid = 1'b1;
      bus.i_mem_rsp_data  = memq[0].data;
      cur_rsp_epoch       = memq[0].epoch;
      void'(memq.pop_front());
    end else begin
      bus.i_mem_rsp_valid = 1'b0;
      bus.i_mem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset(input bit check_first);
    @(negedge clk);
    cyc++;
    arst                = 1'b0;
    pc_src              = 1'b0;
    bus.i_mem_rsp_valid = 1'b0;
    #1;
    chk("rst_req_valid", {63'd0, bus.o_mem_req_valid}, 64'd0);
    chk("rst_o_valid", {63'd0, bus.o_valid}, 64'd0);
    chk("rst_instruction", {32'd0, bus.o_instruction}, 64'd0);
    chk("rst_pc", bus.o_pc, 64'd0);
    chk("rst_pc_plus4", bus.o_pc_plus4, 64'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_misaligned", {63'd0, misaligned}, 64'd0);
`endif
    flush_model();
    want_first = check_first;
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Monitor: checks DUT outputs against the model, then advances the model by one cycle.
  always @(negedge clk) begin
    #1;
    if (arst) begin
      int  inflight;
      bit  exp_rv, exp_ov, popd, live;
      logic [AW-1:0] e;
      inflight = memq.size() + (bus.i_mem_rsp_valid ? 1 : 0);
      exp_rv = !pc_src && !model_mis && (inflight + model_qcnt < DEPTH);
      exp_ov = !pc_src && !model_mis && (model_qcnt != 0);
      chk("req_valid", {63'd0, bus.o_mem_req_valid}, {63'd0, exp_rv});
      chk("o_valid", {63'd0, bus.o_valid}, {63'd0, exp_ov});
      if (hold_pending && !pc_src) chk("req_hold_addr", bus.o_mem_req_addr, hold_addr);
      if (bus.o_mem_req_valid && bus.i_mem_req_ready) begin
        rsp_t r;
        int lat;
        chk("req_addr", bus.o_mem_req_addr, req_exp);
        req_exp += 64'd4;
        lat = $urandom_range(lat_max, lat_min);
        r.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        r.data  = instr_at(bus.o_mem_req_addr);
        r.epoch = epoch;
        last_due = r.due;
        memq.push_back(r);
        fires++;
      end
      popd = bus.o_valid && bus.i_ready;
      if (want_first && bus.o_valid) begin
        chk("first_valid_latency", 64'(cyc - rel_cyc), 64'd2);
        want_first = 0;
      end
      if (popd) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL exp_queue_empty at cycle %0d: got pop with pc %h expected none", cyc, bus.o_pc);
        end else begin
          e = exp_q.pop_front();
          chk("o_pc", bus.o_pc, e);
          chk("o_pc_plus4", bus.o_pc_plus4, e + 64'd4);
          chk("o_instruction", {32'd0, bus.o_instruction}, {32'd0, instr_at(e)});
        end
      end
      live = bus.i_mem_rsp_valid && (cur_rsp_epoch == epoch) && !pc_src;
      model_qcnt += (live ? 1 : 0) - (popd ? 1 : 0);
      hold_pending = bus.o_mem_req_valid && !bus.i_mem_req_ready;
      hold_addr    = bus.o_mem_req_addr;
      if (pc_src) begin
        epoch++;
        model_qcnt   = 0;
        req_exp      = pc_target;
        hold_pending = 0;
`ifdef FETCH_ALIGN_CHECK_EN
        model_mis = |pc_target[1:0];
`endif
      end
    end
  end

  initial begin
    int f0;
    logic [AW-1:0] t;
    arst = 1'b0; pc_src = 1'b0; pc_target = '0;
    bus.i_ready = 1'b0; bus.i_mem_req_ready = 1'b0;
    bus.i_mem_rsp_valid = 1'b0; bus.i_mem_rsp_data = '0;

    // Streaming with 1-cycle memory.
    p_rdy = 100; p_mrdy = 100; lat_min = 1; lat_max = 1;
    do_reset(1);
    repeat (20) step();

    // Decode stall: credits run out after exactly DEPTH requests.
    do_reset(0);
    p_rdy = 0;
    f0 = fires;
    repeat (12) step();
    #2;
    chk("stall_fires", 64'(fires - f0), 64'(DEPTH));
    chk("stall_req_valid", {63'd0, bus.o_mem_req_valid}, 64'd0);
    p_rdy = 100;
    repeat (12) step();

    // Latency 3, redirect with two requests outstanding.
    do_reset(0);
    lat_min = 3; lat_max = 3;
    repeat (2) step();
    step(1, 64'h100);
    repeat (20) step();

    // Redirect coinciding with a response and ready memory.
    lat_min = 1; lat_max = 1;
    repeat (6) step();
    step(1, 64'h180);
    repeat (10) step();

    // Back-to-back redirects.
    lat_min = 2; lat_max = 3;
    step(1, 64'h200);
    step(1, 64'h300);
    repeat (20) step();

    // Randomized traffic, redirects and wrap-around targets.
    for (int blk = 0; blk < 60; blk++) begin
      p_rdy   = $urandom_range(100);
      p_mrdy  = $urandom_range(100, 20);
      lat_min = 1;
      lat_max = $urandom_range(5, 1);
      for (int k = 0; k < 50; k++) begin
        if ($urandom_range(99) < 3) begin
          t = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : ({$urandom, $urandom} & ~64'h3);
          step(1, t);
        end else begin
          step();
        end
      end
    end

    // Reset in the middle of traffic.
    p_rdy = 0; p_mrdy = 100; lat_min = 4; lat_max = 4;
    do_reset(0);
    repeat (6) step();
    do_reset(0);
    p_rdy = 100; lat_min = 1; lat_max = 1;
    repeat (20) step();

`ifdef FETCH_ALIGN_CHECK_EN
    step(1, 64'h102);
    repeat (6) step();
    #2;
    chk("misaligned_set", {63'd0, misaligned}, 64'd1);
    step(1, 64'h400);
    repeat (10) step();
    #2;
    chk("misaligned_clear", {63'd0, misaligned}, 64'd0);
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
